// File: rtl/jstk_pkg.sv
// Shared constants for the PmodJSTK SPI controller: FSM encoding, reply byte
// lanes and the centred-joystick reset value.
package jstk_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_GAP   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int NUM_BYTES = 5;

  localparam int X_LO = 0;
  localparam int X_HI = 1;
  localparam int Y_LO = 2;
  localparam int Y_HI = 3;
  localparam int BTN  = 4;

  // Centre position (512) on both axes, no buttons pressed.
  localparam logic [39:0] JSTK_RESET_DATA = 40'h00_02_00_02_00;

  // Byte 0 arrives first and lands in the top lane of the 40-bit reply.
  function automatic int lane_lsb(input int lane);
    return 8 * (NUM_BYTES - 1 - lane);
  endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// One SPI mode-0 byte: drives sclk/mosi for 8 bits from a CLK_DIV half-period
// counter, samples miso on each sclk rising edge, flags the final falling edge.
module spi_byte_shift #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_tx_byte,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  logic          r_active;
  logic [CW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          r_sclk;
  logic          r_mosi;
  logic          w_tick;

  assign w_tick      = r_active && (r_div == DIV_MAX);
  // Combinational so the caller can move on in the same cycle as the last edge.
  assign o_byte_done = w_tick && r_sclk && (r_bit == 3'd7);
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;
  assign o_rx_byte   = r_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
      r_tx     <= {i_tx_byte[6:0], 1'b0};
      r_mosi   <= i_tx_byte[7];
      r_sclk   <= 1'b0;
    end else if (r_active) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_sclk <= ~r_sclk;
        if (!r_sclk) begin
          r_rx <= {r_rx[6:0], i_miso};
        end else begin
          r_bit  <= r_bit + 3'd1;
          r_mosi <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
          if (r_bit == 3'd7) begin
            r_active <= 1'b0;
            r_mosi   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/jstk_spi_ctrl.sv
// PmodJSTK SPI master: one 5-byte mode-0 transaction per start request, with
// the reply decoded into X/Y positions and button bits for the movement stage.
module jstk_spi_ctrl
  import jstk_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int SS_SETUP = 1500,
  parameter int BYTE_GAP = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  snd_data,
  input  logic        miso,
  output logic        ss,
  output logic        sclk,
  output logic        mosi,
  output logic [39:0] jstk_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  buttons,
  output logic        busy,
  output logic        done
);

  localparam int TW = 16;
  localparam int BW = $clog2(NUM_BYTES);
  localparam int X_LO_LSB = lane_lsb(X_LO);
  localparam int X_HI_LSB = lane_lsb(X_HI);
  localparam int Y_LO_LSB = lane_lsb(Y_LO);
  localparam int Y_HI_LSB = lane_lsb(Y_HI);
  localparam int BTN_LSB  = lane_lsb(BTN);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [BW-1:0] r_byte;
  logic [7:0]    r_cmd;
  logic [31:0]   r_rx_acc;
  logic [39:0]   r_jstk;
  logic          r_ss;
  logic          r_done;

  logic          w_load;
  logic [7:0]    w_tx_byte;
  logic [7:0]    w_rx_byte;
  logic          w_byte_done;

  assign w_load = ((r_state == ST_SETUP) && (r_timer == TW'(SS_SETUP))) ||
                  ((r_state == ST_GAP)   && (r_timer == TW'(BYTE_GAP - 1)));
  assign w_tx_byte = (r_byte == '0) ? r_cmd : 8'h00;

  spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_tx_byte   (w_tx_byte),
    .i_miso      (miso),
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .o_rx_byte   (w_rx_byte),
    .o_byte_done (w_byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_byte   <= '0;
      r_cmd    <= '0;
      r_rx_acc <= '0;
      r_jstk   <= JSTK_RESET_DATA;
      r_ss     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SETUP;
            r_timer <= '0;
            r_byte  <= '0;
            r_cmd   <= snd_data;
          end
        end
        // ss drops one cycle after acceptance; the timer already counts that cycle.
        ST_SETUP: begin
          r_ss    <= 1'b0;
          r_timer <= r_timer + 1'b1;
          if (w_load) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_byte_done) begin
            if (r_byte == BW'(NUM_BYTES - 1)) begin
              r_state <= ST_DONE;
              r_ss    <= 1'b1;
              r_done  <= 1'b1;
              r_jstk  <= {r_rx_acc, w_rx_byte};
            end else begin
              r_state  <= ST_GAP;
              r_timer  <= '0;
              r_byte   <= r_byte + 1'b1;
              r_rx_acc <= {r_rx_acc[23:0], w_rx_byte};
            end
          end
        end
        ST_GAP: begin
          r_timer <= r_timer + 1'b1;
          if (w_load) r_state <= ST_SHIFT;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign ss        = r_ss;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign jstk_data = r_jstk;
  assign x_pos     = {r_jstk[X_HI_LSB +: 2], r_jstk[X_LO_LSB +: 8]};
  assign y_pos     = {r_jstk[Y_HI_LSB +: 2], r_jstk[Y_LO_LSB +: 8]};
  assign buttons   = r_jstk[BTN_LSB +: 3];

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// Directed bench for jstk_spi_ctrl with a mode-0 joystick model on the SPI pins.
module tb_jstk_spi_ctrl;

  localparam int CLK_DIV  = 2;
  localparam int SS_SETUP = 4;
  localparam int BYTE_GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  snd_data;
  logic        miso;
  logic        ss;
  logic        sclk;
  logic        mosi;
  logic [39:0] jstk_data;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  buttons;
  logic        busy;
  logic        done;

  jstk_spi_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .SS_SETUP (SS_SETUP),
    .BYTE_GAP (BYTE_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .snd_data  (snd_data),
    .miso      (miso),
    .ss        (ss),
    .sclk      (sclk),
    .mosi      (mosi),
    .jstk_data (jstk_data),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .buttons   (buttons),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int sclk_ss_err = 0;
  int mosi_err = 0;
  logic prev_mosi = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (rst_n === 1'b1 && ss !== 1'b0 && sclk !== 1'b0) sclk_ss_err++;
    if (sclk === 1'b1 && mosi !== prev_mosi) mosi_err++;
    prev_mosi = mosi;
  end

  // Joystick model: loads its reply when ss falls, shifts miso on sclk falling
  // edges and captures mosi on sclk rising edges.
  logic [39:0] reply_q = '0;
  logic [39:0] m_sh = '0;
  logic [39:0] m_rx = '0;
  int          m_rises = 0;
  logic        m_ss_d = 1'b1;
  logic        m_sclk_d = 1'b0;

  assign miso = m_sh[39];

  always @(ss or sclk) begin
    if (m_ss_d === 1'b1 && ss === 1'b0) begin
      m_sh    = reply_q;
      m_rx    = '0;
      m_rises = 0;
    end else if (ss === 1'b0 && m_sclk_d === 1'b1 && sclk === 1'b0) begin
      m_sh = {m_sh[38:0], 1'b0};
    end else if (ss === 1'b0 && m_sclk_d === 1'b0 && sclk === 1'b1) begin
      m_rx = {m_rx[38:0], mosi};
      m_rises++;
    end
    m_ss_d   = ss;
    m_sclk_d = sclk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Runs one transaction from a negedge; returns at the negedge of the done cycle.
  task automatic run_txn(input logic [39:0] reply, input logic [7:0] snd,
                         input int inj_at, input bit start_in_done,
                         output int lat, output int unstable);
    logic [39:0] j0;
    int t0;
    reply_q  = reply;
    snd_data = snd;
    j0       = jstk_data;
    lat      = -1;
    unstable = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    @(negedge clk);
    check("ss_high_accept_cycle", ss, 1);
    check("busy_after_accept", busy, 1);
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) check("ss_low_next_cycle", ss, 0);
      if (done === 1'b1) begin
        lat = cyc - t0;
        if (start_in_done) start = 1'b1;
        break;
      end
      if (jstk_data !== j0) unstable++;
      if (i == inj_at) start = 1'b1;
      if (i == 3) snd_data = ~snd;
    end
    check("done_within_budget", (lat >= 0), 1);
    $display("txn reply=%h snd=%h latency=%0d data=%h", reply, snd, lat, jstk_data);
  endtask

  int lat;
  int unst;
  int bad;
  int nd0;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    snd_data = 8'h00;

    // Reset values, held with no start
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ss !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);
    check("rst_jstk_data", jstk_data, 40'h0002000200);
    check("rst_x_pos", x_pos, 512);
    check("rst_y_pos", y_pos, 512);
    check("rst_buttons", buttons, 0);
    check("rst_mosi", mosi, 0);

    // Single transaction, decode, MOSI content, snd_data changed mid-flight
    run_txn(40'h2C01F40205, 8'h83, 0, 0, lat, unst);
    check("t2_latency", lat, 177);
    check("t2_jstk_data", jstk_data, 40'h2C01F40205);
    check("t2_x_pos", x_pos, 300);
    check("t2_y_pos", y_pos, 756);
    check("t2_buttons", buttons, 3'b101);
    check("t2_sclk_rises", m_rises, 40);
    check("t3_mosi_bytes", m_rx, 40'h8300000000);
    check("t2_held_until_done", unst, 0);
    @(negedge clk);
    check("t2_done_one_cycle", done, 0);
    check("t2_ss_released", ss, 1);

    // Output stability across a new reply
    run_txn(40'hFF03000000, 8'h81, 0, 0, lat, unst);
    check("t6_x_held_before_done", unst, 0);
    check("t6_x_pos", x_pos, 1023);
    check("t6_y_pos", y_pos, 0);
    check("t6_mosi_bytes", m_rx, 40'h8100000000);
    @(negedge clk);

    // Start while busy (mid-SHIFT and in DONE) is ignored
    nd0 = n_done;
    run_txn(40'h2C01F40205, 8'h82, 30, 1, lat, unst);
    check("t4_latency_mid_start", lat, 177);
    @(negedge clk);
    start = 1'b0;
    check("t4_start_in_done_ignored", busy, 0);
    @(negedge clk);
    check("t4_not_queued_busy", busy, 0);
    check("t4_not_queued_ss", ss, 1);
    check("t4_single_done", n_done - nd0, 1);

    // Back to back: start in first IDLE cycle after DONE
    run_txn(40'h2C01F40205, 8'h82, 0, 0, lat, unst);
    @(negedge clk);
    run_txn(40'h1102330405, 8'h80, 0, 0, lat, unst);
    check("t4_b2b_latency", lat, 177);
    check("t4_b2b_jstk_data", jstk_data, 40'h1102330405);
    @(negedge clk);

    // Reset during byte 2
    reply_q = 40'h2C01F40205;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (m_rises >= 20) break;
    end
    check("t5_reached_byte2", (m_rises >= 20), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_ss", ss, 1);
    check("t5_async_sclk", sclk, 0);
    check("t5_x_pos", x_pos, 512);
    check("t5_y_pos", y_pos, 512);
    check("t5_busy", busy, 0);
    nd0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_no_done", n_done - nd0, 0);

    run_txn(40'hA5033C0106, 8'h80, 0, 0, lat, unst);
    check("t5_after_latency", lat, 177);
    check("t5_after_x_pos", x_pos, 933);
    check("t5_after_y_pos", y_pos, 316);
    check("t5_after_buttons", buttons, 3'b110);
    check("t5_after_mosi", m_rx, 40'h8000000000);
    @(negedge clk);

    check("sclk_low_while_ss_high", sclk_ss_err, 0);
    check("mosi_stable_while_sclk_high", mosi_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
